// File: rtl/reglist_sequencer.sv
// Register-list sequencer: walks the set bits of an N-bit list one per
// handshake, lowest-first or highest-first, reporting the index, the beat
// ordinal, a last-beat flag and the population count of the latched list.
module reglist_sequencer #(
  parameter int N  = 16,
  parameter int IW = 4,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  list,
  input  logic          descend,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] reg_idx,
  output logic [CW-1:0] beat,
  output logic          last,
  output logic [CW-1:0] count,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [N-1:0] LP_ONE = {{(N-1){1'b0}}, 1'b1};

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_pending;
  logic          r_dir;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_beat;

  logic [IW-1:0] w_idx;
  logic          w_single;
  logic          w_accept;
  logic          w_xfer;
  logic [N-1:0]  w_clear;

  logic          w_busy;
  logic          w_out_valid;
  logic [IW-1:0] w_reg_idx;
  logic          w_last;
  logic          w_done;

  // Index of the least significant set bit; 0 for an empty vector.
  function automatic logic [IW-1:0] f_lowest(input logic [N-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  // Index of the most significant set bit; 0 for an empty vector.
  function automatic logic [IW-1:0] f_highest(input logic [N-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  // Number of set bits; CW is wide enough to hold N for an all-ones list.
  function automatic logic [CW-1:0] f_popcount(input logic [N-1:0] v);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + CW'(v[i]);
    end
    return cnt;
  endfunction

  // Selected bit and handshake qualifiers derived from the registered mask
  assign w_idx    = r_dir ? f_highest(r_pending) : f_lowest(r_pending);
  assign w_single = (r_pending != '0) &&
                    ((r_pending & (r_pending - LP_ONE)) == '0);
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_xfer   = (r_state == S_RUN) && out_ready;
  assign w_clear  = LP_ONE << w_idx;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: an empty list skips straight to the done cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (list != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (out_ready && w_single) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode; index and last are forced to 0 outside RUN
  always_comb begin
    w_busy      = 1'b0;
    w_out_valid = 1'b0;
    w_reg_idx   = '0;
    w_last      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_RUN: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        w_reg_idx   = w_idx;
        w_last      = w_single;
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Latch list on accepted start; retire one bit per accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_dir     <= 1'b0;
      r_count   <= '0;
      r_beat    <= '0;
    end else if (w_accept) begin
      r_pending <= list;
      r_dir     <= descend;
      r_count   <= f_popcount(list);
      r_beat    <= '0;
    end else if (w_xfer) begin
      r_pending <= r_pending & ~w_clear;
      r_beat    <= r_beat + CW'(1);
    end
  end

  assign busy      = w_busy;
  assign out_valid = w_out_valid;
  assign reg_idx   = w_reg_idx;
  assign last      = w_last;
  assign done      = w_done;
  assign beat      = r_beat;
  assign count     = r_count;

endmodule

// File: tb/tb_reglist_sequencer.sv
// Directed bench for reglist_sequencer: expected beats are queued when a
// sequence is started and compared as the DUT hands each beat over.
module tb_reglist_sequencer;

  localparam int N  = 16;
  localparam int IW = 4;
  localparam int CW = 5;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic [N-1:0]  list_i;
  logic          descend_i;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] reg_idx;
  logic [CW-1:0] beat;
  logic          last;
  logic [CW-1:0] count;
  logic          done;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [CW-1:0] beat;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   nxfer = 0;
  logic saw_done;
  int   cyc;

  reglist_sequencer #(.N(N), .IW(IW), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_i),
    .list      (list_i),
    .descend   (descend_i),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .reg_idx   (reg_idx),
    .beat      (beat),
    .last      (last),
    .count     (count),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input int bt, input bit lst);
    exp_t e;
    e.idx  = IW'(idx);
    e.beat = CW'(bt);
    e.last = lst;
    sb.push_back(e);
  endtask

  // One clock: sample at the falling edge, then step past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      nxfer++;
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_beat observed idx=%0d expected no beat", reg_idx);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("beat_idx", 32'(reg_idx), 32'(e.idx));
        chk("beat_ord", 32'(beat), 32'(e.beat));
        chk("beat_last", 32'(last), 32'(e.last));
      end
    end
    saw_done = done;
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic [N-1:0] l, input logic d);
    list_i    = l;
    descend_i = d;
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!saw_done && n < bound);
    chk("done_seen", 32'(saw_done), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b1;
    start_i   = 1'b0;
    list_i    = '0;
    descend_i = 1'b0;
    out_ready = 1'b1;
    #2 rst_n  = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Two bits, ascending
    push(0, 0, 1'b0);
    push(15, 1, 1'b1);
    start_seq(16'h8001, 1'b0);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_count", 32'(count), 32'd2);
    wait_done(20, cyc);
    chk("t1_cycles", 32'(cyc), 32'd3);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk("t1_done_after", 32'(done), 32'd0);

    // Four bits, descending
    push(7, 0, 1'b0);
    push(6, 1, 1'b0);
    push(5, 2, 1'b0);
    push(4, 3, 1'b1);
    start_seq(16'h00F0, 1'b1);
    chk("t2_count", 32'(count), 32'd4);
    wait_done(20, cyc);
    chk("t2_cycles", 32'(cyc), 32'd5);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Back-pressure on the first beat
    push(9, 0, 1'b0);
    push(11, 1, 1'b1);
    out_ready = 1'b0;
    nxfer = 0;
    start_seq(16'h0A00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_idx", 32'(reg_idx), 32'd9);
      chk("t3_hold_beat", 32'(beat), 32'd0);
      chk("t3_hold_last", 32'(last), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    wait_done(20, cyc);
    chk("t3_xfers", 32'(nxfer), 32'd2);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Empty list: done in the first cycle, no beats
    nxfer = 0;
    start_seq(16'h0000, 1'b0);
    chk("t4_valid", 32'(out_valid), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_count", 32'(count), 32'd0);
    wait_done(5, cyc);
    chk("t4_cycles", 32'(cyc), 32'd1);
    chk("t4_busy_after", 32'(busy), 32'd0);
    chk("t4_xfers", 32'(nxfer), 32'd0);

    // All ones with ignored start pulses during the run
    nxfer = 0;
    for (int i = 0; i < 16; i++) push(i, i, i == 15);
    start_seq(16'hFFFF, 1'b0);
    list_i    = 16'h0001;
    descend_i = 1'b1;
    start_i   = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    start_i   = 1'b0;
    chk("t5_count_mid", 32'(count), 32'd16);
    wait_done(30, cyc);
    chk("t5_count", 32'(count), 32'h10);
    chk("t5_xfers", 32'(nxfer), 32'd16);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);
    chk("t5_busy_after", 32'(busy), 32'd0);

    // Reset in the middle of a sequence
    for (int i = 0; i < 8; i++) push(i, i, i == 7);
    start_seq(16'h00FF, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_idx", 32'(reg_idx), 32'd0);
    chk("t6_rst_beat", 32'(beat), 32'd0);
    chk("t6_rst_last", 32'(last), 32'd0);
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    sb.delete();
    tick();
    chk("t6_no_done", 32'(saw_done), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("t6_no_done_after", 32'(saw_done), 32'd0);
    push(2, 0, 1'b1);
    start_seq(16'h0004, 1'b0);
    chk("t6_last", 32'(last), 32'd1);
    chk("t6_count", 32'(count), 32'd1);
    wait_done(10, cyc);
    chk("t6_cycles", 32'(cyc), 32'd2);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reglist_sequencer.md
Name: reglist_sequencer

Overview:
Parametrised, sequential successor to the one-hot 16-to-4 encoder. Accepts an arbitrary N-bit register list, not just one-hot, as used by LDM/STM. Emits the index of each set bit, one per handshake, in ascending or descending order. Also provides the population count and a beat ordinal for the load/store address generator.

Parameters:
N, 16, width of the register list
IW, 4, index width; must equal clog2(N)
CW, 5, count/beat width; must equal clog2(N+1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  load list and begin sequencing; honoured only when busy=0
list  in  N  register list, sampled on accepted start
descend  in  1  0 = lowest set bit first, 1 = highest first; sampled with start
busy  out  1  high from cycle after accepted start until done cycle inclusive
out_valid  out  1  reg_idx/beat/last valid
out_ready  in  1  consumer accepts current beat
reg_idx  out  IW  index of current set bit
beat  out  CW  ordinal of current beat, 0..count-1
last  out  1  current beat is the final one
count  out  CW  popcount of latched list; held until next accepted start
done  out  1  one-cycle pulse when sequence completes

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE; pending mask, busy, out_valid, reg_idx, beat, last, count, done all 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge t latches pending<=list, dir<=descend, count<=popcount(list), beat<=0.
  - If list != 0: next state RUN; out_valid=1 from cycle t+1.
  - If list == 0: next state DONE; count=0; no valid beat ever issued.
- RUN:
  - out_valid=1.
  - reg_idx = lowest set bit of pending (dir=0) or highest (dir=1); combinational from the registered pending mask.
  - last=1 iff pending has exactly one bit set.
  - Beat transfers on an edge with out_valid&out_ready. It clears that bit in pending and increments beat.
  - On transfer with last=1: next state DONE; out_valid=0 next cycle.
  - out_ready=0: reg_idx, beat, last and pending held stable; no bit lost or duplicated.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE; busy=0.
- start while busy=1: ignored completely. list, descend and count unchanged.
- start in IDLE on the edge DONE->IDLE would be accepted: not possible, since DONE is a busy cycle. Earliest restart is the cycle after done.
- Throughput: one beat per cycle with out_ready held high. Total cycles from start edge to done pulse = popcount+1 (empty list: 1).
- Outputs are don't-care semantically when out_valid=0 but must be deterministic; reg_idx/last are driven 0 when not RUN.
- Widths: count and beat never exceed N; count=N for all-ones list requires the CW width.
- rst_n asserted mid-sequence: immediate return to reset values. The pending list is discarded and no done pulse is issued.
- Cycle-level behaviour is identical for any N >= 2 meeting the IW/CW constraints.

Test Plan:
- list=16'h8001, descend=0, ready=1 -> beats (idx 0, beat 0, last 0), (idx 15, beat 1, last 1); count=2; done 3 cycles after start.
- list=16'h00F0, descend=1 -> idx 7,6,5,4 with beat 0..3; last only on idx 4; count=4.
- list=16'h0A00, out_ready low 3 cycles on first beat -> idx 9 held stable 4 cycles, then idx 11; exactly 2 transfers.
- list=16'h0000 -> no out_valid; count=0; done pulse at cycle t+1; busy high only that cycle.
- list=16'hFFFF, descend=0 -> 16 consecutive beats idx 0..15; count=16 (5'b10000); start pulses during the run ignored.
- rst_n low after beat 2 of list=16'h00FF -> all outputs 0 asynchronously; no done. New start with 16'h0004 yields single beat idx 2 with last=1.
